// File: rtl/frontend_pipe_stage_pkg.sv
// Shared types and defaults for the front-end pipeline stage.
//   pipe_occ_e     : occupancy state of the stage (encoding equals entry count)
//   lane_payload_t : producer packing of one lane payload (pc/imm/ctrl)
//   DEF_*          : default parameter values used by the stage and its interface
package frontend_pipe_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_occ_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [23:0] imm;
    logic [7:0]  ctrl;
  } lane_payload_t;

  localparam int DEF_LANES  = 2;
  localparam int DEF_DATA_W = $bits(lane_payload_t);
  localparam int DEF_SEQ_W  = 6;

endpackage

// File: rtl/frontend_pipe_stage_if.sv
// Handshake/bundle channel of the front-end pipeline stage.
//   slave  : the stage's view (receives input bundle + out_ready, drives outputs)
//   master : the environment's view (producer and consumer side together)
// Signal names follow the stage's port list; _i/_o are relative to the stage.
interface frontend_pipe_stage_if #(
  parameter int LANES  = frontend_pipe_stage_pkg::DEF_LANES,
  parameter int DATA_W = frontend_pipe_stage_pkg::DEF_DATA_W,
  parameter int SEQ_W  = frontend_pipe_stage_pkg::DEF_SEQ_W
);
  logic                    flush_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [LANES-1:0]        in_lane_vld_i;
  logic [LANES*DATA_W-1:0] in_data_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [LANES-1:0]        out_lane_vld_o;
  logic [LANES*DATA_W-1:0] out_data_o;
  logic [SEQ_W-1:0]        out_seq_o;
  logic [1:0]              occ_o;

  modport slave (
    input  flush_i, in_valid_i, in_lane_vld_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_lane_vld_o, out_data_o, out_seq_o, occ_o
  );

  modport master (
    output flush_i, in_valid_i, in_lane_vld_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_lane_vld_o, out_data_o, out_seq_o, occ_o
  );
endinterface

// File: rtl/frontend_pipe_stage_entry_reg.sv
// One bundle entry: load-enabled register of {lane mask, payloads, seq tag}.
//   clk, rst           : clock, async active-low clear
//   i_load             : capture i_* on the rising edge
//   i_lane_vld/data/seq: bundle to capture
//   o_lane_vld/data/seq: held bundle
module frontend_pipe_stage_entry_reg #(
  parameter int LANES  = 2,
  parameter int DATA_W = 64,
  parameter int SEQ_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic [LANES-1:0]        i_lane_vld,
  input  logic [LANES*DATA_W-1:0] i_data,
  input  logic [SEQ_W-1:0]        i_seq,
  output logic [LANES-1:0]        o_lane_vld,
  output logic [LANES*DATA_W-1:0] o_data,
  output logic [SEQ_W-1:0]        o_seq
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_lane_vld <= '0;
      o_data     <= '0;
      o_seq      <= '0;
    end else if (i_load) begin
      o_lane_vld <= i_lane_vld;
      o_data     <= i_data;
      o_seq      <= i_seq;
    end
  end

endmodule

// File: rtl/frontend_pipe_stage.sv
// N-lane front-end pipeline stage with valid/ready handshake, flush and
// per-bundle sequence tagging. SKID=1 holds two bundles (full throughput,
// registered ready); SKID=0 holds one (one bundle every two cycles).
//   clk, rst : clock, async active-low reset
//   bus      : slave side of frontend_pipe_stage_if (input bundle, output head,
//              flush, occupancy)
//
// state | meaning
// EMPTY | no bundle held
// ONE   | head bundle in main entry
// TWO   | head in main, second bundle in skid (SKID=1 only), input stalled
module frontend_pipe_stage
  import frontend_pipe_stage_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SKID   = 1,
  parameter int SEQ_W  = DEF_SEQ_W
) (
  input logic                 clk,
  input logic                 rst,
  frontend_pipe_stage_if.slave bus
);

  localparam int W = LANES * DATA_W;

  pipe_occ_e        r_state;
  pipe_occ_e        w_next;
  logic             r_in_ready;
  logic [SEQ_W-1:0] r_seq;

  logic             w_accept, w_pop, w_load_main, w_load_skid, w_from_skid;
  logic [W-1:0]     w_in_data_m;

  logic [LANES-1:0] w_main_vld_d, w_skid_vld;
  logic [W-1:0]     w_main_data_d, w_skid_data;
  logic [SEQ_W-1:0] w_main_seq_d, w_skid_seq;

  // Lanes without their mask bit are stored as zero so stale producer bits
  // never leak downstream.
  for (genvar l = 0; l < LANES; l++) begin : g_mask
    assign w_in_data_m[l*DATA_W +: DATA_W] =
      bus.in_lane_vld_i[l] ? bus.in_data_i[l*DATA_W +: DATA_W] : '0;
  end

  // A zero-mask bundle is consumed by the handshake but never becomes an entry.
  assign w_accept = bus.in_valid_i & r_in_ready & (|bus.in_lane_vld_i) & ~bus.flush_i;
  assign w_pop    = (r_state != EMPTY) & bus.out_ready_i & ~bus.flush_i;

  always_comb begin
    w_next      = r_state;
    w_load_main = 1'b0;
    w_load_skid = 1'b0;
    w_from_skid = 1'b0;
    if (bus.flush_i) begin
      w_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_accept) begin
          w_next      = ONE;
          w_load_main = 1'b1;
        end
        ONE: begin
          if (w_accept && w_pop) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            w_next      = TWO;
            w_load_skid = 1'b1;
          end else if (w_pop) begin
            w_next = EMPTY;
          end
        end
        TWO: if (w_pop) begin
          w_next      = ONE;
          w_load_main = 1'b1;
          w_from_skid = 1'b1;
        end
        default: w_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      // Ready is a flop of the next occupancy, so no comb path from out_ready.
      r_in_ready <= (SKID != 0) ? (w_next != TWO) : (w_next == EMPTY);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_seq <= '0;
    else if (bus.flush_i) r_seq <= '0;
    else if (w_accept)    r_seq <= r_seq + 1'b1;
  end

  assign w_main_vld_d  = w_from_skid ? w_skid_vld  : bus.in_lane_vld_i;
  assign w_main_data_d = w_from_skid ? w_skid_data : w_in_data_m;
  assign w_main_seq_d  = w_from_skid ? w_skid_seq  : r_seq;

  frontend_pipe_stage_entry_reg #(.LANES(LANES), .DATA_W(DATA_W), .SEQ_W(SEQ_W)) u_main (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load_main),
    .i_lane_vld (w_main_vld_d),
    .i_data     (w_main_data_d),
    .i_seq      (w_main_seq_d),
    .o_lane_vld (bus.out_lane_vld_o),
    .o_data     (bus.out_data_o),
    .o_seq      (bus.out_seq_o)
  );

  if (SKID != 0) begin : g_skid
    frontend_pipe_stage_entry_reg #(.LANES(LANES), .DATA_W(DATA_W), .SEQ_W(SEQ_W)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load_skid),
      .i_lane_vld (bus.in_lane_vld_i),
      .i_data     (w_in_data_m),
      .i_seq      (r_seq),
      .o_lane_vld (w_skid_vld),
      .o_data     (w_skid_data),
      .o_seq      (w_skid_seq)
    );
  end else begin : g_noskid
    // Single-entry mode never reaches TWO, so the skid load is dead here.
    logic w_unused_skid_load;
    assign w_unused_skid_load = w_load_skid;
    assign w_skid_vld  = '0;
    assign w_skid_data = '0;
    assign w_skid_seq  = '0;
  end

  assign bus.in_ready_o  = r_in_ready;
  assign bus.out_valid_o = (r_state != EMPTY);
  assign bus.occ_o       = r_state;

endmodule

// File: tb/tb_frontend_pipe_stage.sv
module tb_frontend_pipe_stage;

  typedef struct packed {
    logic [1:0]   m;
    logic [127:0] d;
    logic [5:0]   s;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errs   = 0;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [5:0] sq0 = '0;
  logic [2:0] sq1 = '0;

  always #5 clk = ~clk;

  frontend_pipe_stage_if #(.LANES(2), .DATA_W(64), .SEQ_W(6)) b0 ();
  frontend_pipe_stage_if #(.LANES(2), .DATA_W(64), .SEQ_W(3)) b1 ();

  frontend_pipe_stage #(.LANES(2), .DATA_W(64), .SKID(1), .SEQ_W(6)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave));
  frontend_pipe_stage #(.LANES(2), .DATA_W(64), .SKID(0), .SEQ_W(3)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));

  function automatic logic [127:0] mask_data(input logic [1:0] m, input logic [127:0] d);
    logic [127:0] r;
    r[63:0]   = m[0] ? d[63:0]   : 64'h0;
    r[127:64] = m[1] ? d[127:64] : 64'h0;
    return r;
  endfunction

  // Scoreboard for the SKID=1 stage: push on accepted input, pop on output handshake.
  logic         hold0 = 1'b0;
  logic [1:0]   p0_m;
  logic [127:0] p0_d;
  logic [5:0]   p0_s;
  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst) begin
      q0.delete(); sq0 = '0; hold0 = 1'b0;
    end else begin
      n_checks++;
      if (b0.out_valid_o !== (q0.size() != 0)) begin
        n_errs++; $display("FAIL mon0_valid: got %b want %b", b0.out_valid_o, q0.size() != 0);
      end
      n_checks++;
      if (b0.occ_o !== 2'(q0.size())) begin
        n_errs++; $display("FAIL mon0_occ: got %0d want %0d", b0.occ_o, q0.size());
      end
      if (hold0) begin
        n_checks++;
        if (b0.out_lane_vld_o !== p0_m || b0.out_data_o !== p0_d || b0.out_seq_o !== p0_s) begin
          n_errs++; $display("FAIL mon0_stable: got m=%b s=%0d d=%h want m=%b s=%0d d=%h",
                             b0.out_lane_vld_o, b0.out_seq_o, b0.out_data_o, p0_m, p0_s, p0_d);
        end
      end
      if (b0.flush_i) begin
        q0.delete(); sq0 = '0;
      end else begin
        if (b0.out_valid_o && b0.out_ready_i) begin
          n_checks++;
          if (q0.size() == 0) begin
            n_errs++; $display("FAIL mon0_pop: got unexpected bundle s=%0d want none", b0.out_seq_o);
          end else begin
            e = q0.pop_front();
            if (b0.out_lane_vld_o !== e.m || b0.out_data_o !== e.d || b0.out_seq_o !== e.s) begin
              n_errs++; $display("FAIL mon0_data: got m=%b s=%0d d=%h want m=%b s=%0d d=%h",
                                 b0.out_lane_vld_o, b0.out_seq_o, b0.out_data_o, e.m, e.s, e.d);
            end
          end
        end
        if (b0.in_valid_i && b0.in_ready_o && (|b0.in_lane_vld_i)) begin
          e.m = b0.in_lane_vld_i; e.d = mask_data(b0.in_lane_vld_i, b0.in_data_i); e.s = sq0;
          q0.push_back(e); sq0 = sq0 + 6'd1;
        end
      end
      hold0 = b0.out_valid_o && !b0.out_ready_i && !b0.flush_i;
      p0_m = b0.out_lane_vld_o; p0_d = b0.out_data_o; p0_s = b0.out_seq_o;
    end
  end

  // Scoreboard for the SKID=0 stage (3-bit sequence tag).
  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst) begin
      q1.delete(); sq1 = '0;
    end else begin
      n_checks++;
      if (b1.out_valid_o !== (q1.size() != 0) || b1.occ_o !== 2'(q1.size())) begin
        n_errs++; $display("FAIL mon1_occ: got v=%b occ=%0d want occ=%0d", b1.out_valid_o, b1.occ_o, q1.size());
      end
      if (b1.flush_i) begin
        q1.delete(); sq1 = '0;
      end else begin
        if (b1.out_valid_o && b1.out_ready_i) begin
          n_checks++;
          if (q1.size() == 0) begin
            n_errs++; $display("FAIL mon1_pop: got unexpected bundle s=%0d want none", b1.out_seq_o);
          end else begin
            e = q1.pop_front();
            if (b1.out_lane_vld_o !== e.m || b1.out_data_o !== e.d || b1.out_seq_o !== e.s[2:0]) begin
              n_errs++; $display("FAIL mon1_data: got m=%b s=%0d d=%h want m=%b s=%0d d=%h",
                                 b1.out_lane_vld_o, b1.out_seq_o, b1.out_data_o, e.m, e.s[2:0], e.d);
            end
          end
        end
        if (b1.in_valid_i && b1.in_ready_o && (|b1.in_lane_vld_i)) begin
          e.m = b1.in_lane_vld_i; e.d = mask_data(b1.in_lane_vld_i, b1.in_data_i); e.s = {3'b000, sq1};
          q1.push_back(e); sq1 = sq1 + 3'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drv0(input logic v, input logic [1:0] m, input logic [127:0] d);
    b0.in_valid_i = v; b0.in_lane_vld_i = m; b0.in_data_i = d;
  endtask

  task automatic flush0();
    b0.flush_i = 1'b1; tick(); b0.flush_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if (b0.out_valid_o !== 1'b0 || b0.occ_o !== 2'd0 || b0.in_ready_o !== 1'b0 ||
        b0.out_data_o !== 128'h0 || b0.out_seq_o !== 6'd0 || b0.out_lane_vld_o !== 2'b00) begin
      n_errs++; $display("FAIL reset_init: got v=%b occ=%0d rdy=%b s=%0d want 0 0 0 0",
                         b0.out_valid_o, b0.occ_o, b0.in_ready_o, b0.out_seq_o);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (b0.in_ready_o !== 1'b1 || b1.in_ready_o !== 1'b1) begin
      n_errs++; $display("FAIL reset_release_rdy: got %b/%b want 1/1", b0.in_ready_o, b1.in_ready_o);
    end
    b0.out_ready_i = 1'b0;
    drv0(1'b1, 2'b11, {64'h11, 64'h10}); tick();
    drv0(1'b1, 2'b11, {64'h21, 64'h20}); tick();
    drv0(1'b0, 2'b00, '0);
    n_checks++;
    if (b0.occ_o !== 2'd2) begin
      n_errs++; $display("FAIL reset_pre_occ: got %0d want 2", b0.occ_o);
    end
    rst = 1'b0; #1;
    n_checks++;
    if (b0.out_valid_o !== 1'b0 || b0.occ_o !== 2'd0 || b0.in_ready_o !== 1'b0 ||
        b0.out_data_o !== 128'h0 || b0.out_lane_vld_o !== 2'b00) begin
      n_errs++; $display("FAIL reset_async: got v=%b occ=%0d rdy=%b want 0 0 0",
                         b0.out_valid_o, b0.occ_o, b0.in_ready_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (b0.in_ready_o !== 1'b0) begin
        n_errs++; $display("FAIL reset_hold_rdy: got %b want 0 (cycle %0d)", b0.in_ready_o, i);
      end
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (b0.in_ready_o !== 1'b1 || b0.occ_o !== 2'd0) begin
      n_errs++; $display("FAIL reset_rerelease: got rdy=%b occ=%0d want 1 0", b0.in_ready_o, b0.occ_o);
    end
  endtask

  task automatic test_back_to_back();
    b0.out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drv0(1'b1, 2'b11, {64'(i), 64'(i)});
      if (i > 0) begin
        n_checks++;
        if (b0.out_valid_o !== 1'b1 || b0.out_seq_o !== 6'(i - 1) ||
            b0.out_data_o[63:0] !== 64'(i - 1) || b0.in_ready_o !== 1'b1) begin
          n_errs++; $display("FAIL b2b_stream: got v=%b s=%0d d=%0d rdy=%b want 1 %0d %0d 1",
                             b0.out_valid_o, b0.out_seq_o, b0.out_data_o[63:0], b0.in_ready_o, i - 1, i - 1);
        end
      end
      tick();
    end
    drv0(1'b0, 2'b00, '0);
    n_checks++;
    if (b0.out_valid_o !== 1'b1 || b0.out_seq_o !== 6'd7) begin
      n_errs++; $display("FAIL b2b_last: got v=%b s=%0d want 1 7", b0.out_valid_o, b0.out_seq_o);
    end
    tick();
  endtask

  task automatic test_backpressure();
    flush0();
    b0.out_ready_i = 1'b0;
    drv0(1'b1, 2'b11, {64'hA1, 64'hA0}); tick();
    drv0(1'b1, 2'b11, {64'hB1, 64'hB0}); tick();
    drv0(1'b1, 2'b11, {64'hC1, 64'hC0});
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (b0.occ_o !== 2'd2 || b0.in_ready_o !== 1'b0 || b0.out_data_o[63:0] !== 64'hA0 ||
          b0.out_seq_o !== 6'd0) begin
        n_errs++; $display("FAIL bp_hold: got occ=%0d rdy=%b d=%h s=%0d want 2 0 a0 0",
                           b0.occ_o, b0.in_ready_o, b0.out_data_o[63:0], b0.out_seq_o);
      end
      tick();
    end
    b0.out_ready_i = 1'b1;
    tick();
    n_checks++;
    if (b0.out_seq_o !== 6'd1 || b0.out_data_o[63:0] !== 64'hB0 || b0.in_ready_o !== 1'b1 ||
        b0.occ_o !== 2'd1) begin
      n_errs++; $display("FAIL bp_second: got s=%0d d=%h rdy=%b occ=%0d want 1 b0 1 1",
                         b0.out_seq_o, b0.out_data_o[63:0], b0.in_ready_o, b0.occ_o);
    end
    tick();
    drv0(1'b0, 2'b00, '0);
    n_checks++;
    if (b0.out_seq_o !== 6'd2 || b0.out_data_o[63:0] !== 64'hC0 || b0.occ_o !== 2'd1) begin
      n_errs++; $display("FAIL bp_third: got s=%0d d=%h occ=%0d want 2 c0 1",
                         b0.out_seq_o, b0.out_data_o[63:0], b0.occ_o);
    end
    tick();
  endtask

  task automatic test_flush();
    b0.out_ready_i = 1'b0;
    drv0(1'b1, 2'b11, {64'hD1, 64'hD0}); tick();
    drv0(1'b1, 2'b11, {64'hD3, 64'hD2}); tick();
    n_checks++;
    if (b0.occ_o !== 2'd2) begin
      n_errs++; $display("FAIL flush_pre_occ: got %0d want 2", b0.occ_o);
    end
    drv0(1'b1, 2'b11, {64'hD5, 64'hD4});
    b0.flush_i = 1'b1; b0.out_ready_i = 1'b1;
    tick();
    b0.flush_i = 1'b0;
    drv0(1'b0, 2'b00, '0);
    n_checks++;
    if (b0.occ_o !== 2'd0 || b0.out_valid_o !== 1'b0 || b0.in_ready_o !== 1'b1) begin
      n_errs++; $display("FAIL flush_clear: got occ=%0d v=%b rdy=%b want 0 0 1",
                         b0.occ_o, b0.out_valid_o, b0.in_ready_o);
    end
    drv0(1'b1, 2'b11, {64'hE1, 64'hE0}); tick();
    drv0(1'b0, 2'b00, '0);
    n_checks++;
    if (b0.out_valid_o !== 1'b1 || b0.out_seq_o !== 6'd0 || b0.out_data_o[63:0] !== 64'hE0) begin
      n_errs++; $display("FAIL flush_seq0: got v=%b s=%0d d=%h want 1 0 e0",
                         b0.out_valid_o, b0.out_seq_o, b0.out_data_o[63:0]);
    end
    tick();
  endtask

  task automatic test_mask();
    b0.out_ready_i = 1'b0;
    drv0(1'b1, 2'b00, {64'h77, 64'h66}); tick();
    drv0(1'b0, 2'b00, '0);
    n_checks++;
    if (b0.occ_o !== 2'd0 || b0.out_valid_o !== 1'b0) begin
      n_errs++; $display("FAIL mask_zero: got occ=%0d v=%b want 0 0", b0.occ_o, b0.out_valid_o);
    end
    drv0(1'b1, 2'b01, {64'hFFFF, 64'h1234}); tick();
    drv0(1'b0, 2'b00, '0);
    n_checks++;
    if (b0.out_lane_vld_o !== 2'b01 || b0.out_data_o[127:64] !== 64'h0 ||
        b0.out_data_o[63:0] !== 64'h1234 || b0.out_seq_o !== 6'd1) begin
      n_errs++; $display("FAIL mask_lane: got m=%b d1=%h d0=%h s=%0d want 01 0 1234 1",
                         b0.out_lane_vld_o, b0.out_data_o[127:64], b0.out_data_o[63:0], b0.out_seq_o);
    end
    b0.out_ready_i = 1'b1;
    tick();
  endtask

  task automatic test_wrap_noskid();
    int n = 0, popped = 0, cyc = 0, last = 0;
    b1.flush_i = 1'b1; tick(); b1.flush_i = 1'b0;
    b1.out_ready_i = 1'b1;
    while (popped < 10 && cyc < 60) begin
      b1.in_valid_i = (n < 10); b1.in_lane_vld_i = 2'b11; b1.in_data_i = {64'(n + 100), 64'(n)};
      n_checks++;
      if (b1.occ_o > 2'd1) begin
        n_errs++; $display("FAIL noskid_occ: got %0d want <=1", b1.occ_o);
      end
      if (b1.out_valid_o) begin
        n_checks++;
        if (b1.out_seq_o !== 3'(popped)) begin
          n_errs++; $display("FAIL wrap_seq: got %0d want %0d", b1.out_seq_o, 3'(popped));
        end
        popped++;
      end
      if (n < 10 && b1.in_ready_o) begin
        if (n > 0) begin
          n_checks++;
          if (cyc - last != 2) begin
            n_errs++; $display("FAIL noskid_rate: got gap %0d want 2", cyc - last);
          end
        end
        last = cyc; n++;
      end
      tick(); cyc++;
    end
    b1.in_valid_i = 1'b0;
    n_checks++;
    if (popped != 10) begin
      n_errs++; $display("FAIL wrap_timeout: got %0d bundles want 10", popped);
    end
    tick();
  endtask

  initial begin
    b0.flush_i = 1'b0; b0.in_valid_i = 1'b0; b0.in_lane_vld_i = '0; b0.in_data_i = '0; b0.out_ready_i = 1'b0;
    b1.flush_i = 1'b0; b1.in_valid_i = 1'b0; b1.in_lane_vld_i = '0; b1.in_data_i = '0; b1.out_ready_i = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_mask();
    test_wrap_noskid();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
